// File: rtl/peripheral_display_scan.sv
// peripheral_display_scan
//
// Time-multiplexed driver for a bank of common-anode 7-segment digits.
// A load strobe copies the packed nibble vector, per-digit modes and the
// leading-zero enable into shadow registers. The scanner then lights one
// digit per slot of PRESCALE cycles. It keeps all anodes off for the first
// GUARD cycles of each slot to avoid ghosting. Blinking digits alternate
// every BLINK_DIV frames.
//
// Ports:
//   clk        in   system clock, all state on the rising edge
//   reset      in   synchronous, active-high reset
//   value      in   4*N_DIGITS packed nibbles, digit 0 in value[3:0]
//   mode       in   2*N_DIGITS per-digit modes:
//                   00 hex, 01 blank, 10 minus, 11 blinking hex
//   lz_en      in   leading-zero blanking enable
//   load       in   one-cycle strobe capturing value/mode/lz_en
//   seg        out  segments gfedcba, active-low, registered
//   an         out  anodes, active-low, at most one low, registered
//   frame_tick out  one-cycle pulse at the end of each full scan, registered
module peripheral_display_scan #(
    parameter int N_DIGITS  = 4,
    parameter int PRESCALE  = 50000,
    parameter int GUARD     = 2,
    parameter int BLINK_DIV = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*N_DIGITS-1:0]   value,
    input  logic [2*N_DIGITS-1:0]   mode,
    input  logic                    lz_en,
    input  logic                    load,
    output logic [6:0]              seg,
    output logic [N_DIGITS-1:0]     an,
    output logic                    frame_tick
);

    localparam int PW = (PRESCALE  > 1) ? $clog2(PRESCALE)  : 1;
    localparam int IW = (N_DIGITS  > 1) ? $clog2(N_DIGITS)  : 1;
    localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [PW-1:0] P_LAST  = PW'(PRESCALE - 1);
    localparam logic [PW-1:0] P_GUARD = PW'(GUARD);
    localparam logic [IW-1:0] I_LAST  = IW'(N_DIGITS - 1);
    localparam logic [FW-1:0] F_LAST  = FW'(BLINK_DIV - 1);

    localparam logic [1:0] MODE_HEX   = 2'b00;
    localparam logic [1:0] MODE_BLANK = 2'b01;
    localparam logic [1:0] MODE_MINUS = 2'b10;
    localparam logic [1:0] MODE_BLINK = 2'b11;

    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;
    localparam logic [6:0] GLYPH_MINUS = 7'b0111111;

    // Active-low gfedcba pattern for one hex nibble.
    function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0:    g = 7'b1000000;
            4'h1:    g = 7'b1111001;
            4'h2:    g = 7'b0100100;
            4'h3:    g = 7'b0110000;
            4'h4:    g = 7'b0011001;
            4'h5:    g = 7'b0010010;
            4'h6:    g = 7'b0000010;
            4'h7:    g = 7'b1111000;
            4'h8:    g = 7'b0000000;
            4'h9:    g = 7'b0011000;
            4'hA:    g = 7'b0001000;
            4'hB:    g = 7'b0000011;
            4'hC:    g = 7'b1000110;
            4'hD:    g = 7'b0100001;
            4'hE:    g = 7'b0000110;
            4'hF:    g = 7'b0001110;
            default: g = GLYPH_BLANK;
        endcase
        return g;
    endfunction

    // Scan and shadow state
    logic [PW-1:0]          pcnt_r;
    logic [IW-1:0]          idx_r;
    logic [FW-1:0]          fcnt_r;
    logic                   bp_r;
    logic [4*N_DIGITS-1:0]  value_r;
    logic [2*N_DIGITS-1:0]  mode_r;
    logic                   lz_r;

    // Registered outputs
    logic [6:0]             seg_r;
    logic [N_DIGITS-1:0]    an_r;
    logic                   frame_tick_r;

    // Combinational helpers
    logic                   slot_end_s;
    logic                   frame_end_s;
    logic [3:0]             nib_s [N_DIGITS];
    logic [1:0]             md_s  [N_DIGITS];
    logic [N_DIGITS-1:0]    lz_blank_s;
    logic                   lz_run_s;
    logic [3:0]             cur_nib_s;
    logic [1:0]             cur_mode_s;
    logic [6:0]             glyph_s;
    logic [N_DIGITS-1:0]    an_s;

    assign slot_end_s  = (pcnt_r == P_LAST);
    assign frame_end_s = slot_end_s && (idx_r == I_LAST);

    // Split the shadow vectors into per-digit nibbles and modes.
    always_comb begin
        for (int i = 0; i < N_DIGITS; i++) begin
            nib_s[i] = value_r[4*i +: 4];
            md_s[i]  = mode_r[2*i +: 2];
        end
    end

    // Leading-zero mask: a digit blanks only if it and every higher digit
    // are hex-mode zeros; the run is walked from the top digit downward.
    always_comb begin
        lz_blank_s = {N_DIGITS{1'b0}};
        lz_run_s   = 1'b1;
        for (int i = N_DIGITS - 1; i >= 1; i--) begin
            lz_run_s = lz_run_s
                       && ((md_s[i] == MODE_HEX) || (md_s[i] == MODE_BLINK))
                       && (nib_s[i] == 4'h0);
            lz_blank_s[i] = lz_run_s && lz_r;
        end
    end

    // Glyph for the digit currently selected by idx (first rule wins).
    always_comb begin
        cur_nib_s  = nib_s[idx_r];
        cur_mode_s = md_s[idx_r];
        if (cur_mode_s == MODE_BLANK) begin
            glyph_s = GLYPH_BLANK;
        end else if ((cur_mode_s == MODE_BLINK) && bp_r) begin
            glyph_s = GLYPH_BLANK;
        end else if (lz_blank_s[idx_r]) begin
            glyph_s = GLYPH_BLANK;
        end else if (cur_mode_s == MODE_MINUS) begin
            glyph_s = GLYPH_MINUS;
        end else begin
            glyph_s = hex_glyph(cur_nib_s);
        end
    end

    // Anode pattern: all off during the guard interval, else only idx low.
    always_comb begin
        an_s = {N_DIGITS{1'b1}};
        if (pcnt_r < P_GUARD) begin
            an_s = {N_DIGITS{1'b1}};
        end else begin
            an_s[idx_r] = 1'b0;
        end
    end

    // Shadow capture, prescaler, digit index and blink phase.
    always_ff @(posedge clk) begin
        if (reset) begin
            pcnt_r  <= {PW{1'b0}};
            idx_r   <= {IW{1'b0}};
            fcnt_r  <= {FW{1'b0}};
            bp_r    <= 1'b0;
            value_r <= {(4*N_DIGITS){1'b0}};
            mode_r  <= {(2*N_DIGITS){1'b0}};
            lz_r    <= 1'b0;
        end else begin
            if (load) begin
                value_r <= value;
                mode_r  <= mode;
                lz_r    <= lz_en;
            end
            pcnt_r <= slot_end_s ? {PW{1'b0}} : (pcnt_r + PW'(1));
            if (slot_end_s) begin
                idx_r <= frame_end_s ? {IW{1'b0}} : (idx_r + IW'(1));
            end
            if (frame_end_s) begin
                if (fcnt_r == F_LAST) begin
                    fcnt_r <= {FW{1'b0}};
                    bp_r   <= ~bp_r;
                end else begin
                    fcnt_r <= fcnt_r + FW'(1);
                end
            end
        end
    end

    // Output registers: one cycle behind the scan state they reflect.
    always_ff @(posedge clk) begin
        if (reset) begin
            seg_r        <= GLYPH_BLANK;
            an_r         <= {N_DIGITS{1'b1}};
            frame_tick_r <= 1'b0;
        end else begin
            seg_r        <= glyph_s;
            an_r         <= an_s;
            frame_tick_r <= frame_end_s;
        end
    end

    assign seg        = seg_r;
    assign an         = an_r;
    assign frame_tick = frame_tick_r;

endmodule

// File: tb/tb_peripheral_display_scan.sv
// Directed testbench for peripheral_display_scan with N_DIGITS=4,
// PRESCALE=4, GUARD=1, BLINK_DIV=2. After a reset release, the output
// seen after the k-th edge reflects scan state c = k-1, where
// pcnt = c % 4 and idx = (c / 4) % 4.
module tb_peripheral_display_scan;

    localparam int N_DIGITS  = 4;
    localparam int PRESCALE  = 4;
    localparam int GUARD     = 1;
    localparam int BLINK_DIV = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] value;
    logic [7:0]  mode;
    logic        lz_en;
    logic        load;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame_tick;

    int n_checks = 0;
    int n_fail   = 0;

    peripheral_display_scan #(
        .N_DIGITS (N_DIGITS),
        .PRESCALE (PRESCALE),
        .GUARD    (GUARD),
        .BLINK_DIV(BLINK_DIV)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .value     (value),
        .mode      (mode),
        .lz_en     (lz_en),
        .load      (load),
        .seg       (seg),
        .an        (an),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One reset edge, then release with the given contents on load for edge 1.
    task automatic restart_and_load(input logic [15:0] v, input logic [7:0] m, input logic lz);
        reset = 1'b1;
        load  = 1'b0;
        step();
        reset = 1'b0;
        value = v;
        mode  = m;
        lz_en = lz;
        load  = 1'b1;
        step();
        load  = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] exp_an [6];
        exp_an = '{4'b1111, 4'b1110, 4'b1110, 4'b1110, 4'b1111, 4'b1101};
        reset = 1'b1;
        load  = 1'b0;
        value = 16'h0000;
        mode  = 8'h00;
        lz_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            n_checks++;
            if (seg !== 7'b1111111) begin
                n_fail++;
                $display("FAIL reset_seg k=%0d: got %b expected 1111111", k, seg);
            end
            n_checks++;
            if (an !== 4'b1111) begin
                n_fail++;
                $display("FAIL reset_an k=%0d: got %b expected 1111", k, an);
            end
            n_checks++;
            if (frame_tick !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_tick k=%0d: got %b expected 0", k, frame_tick);
            end
        end
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            n_checks++;
            if (an !== exp_an[k]) begin
                n_fail++;
                $display("FAIL post_reset_an k=%0d: got %b expected %b", k, an, exp_an[k]);
            end
            n_checks++;
            if (seg !== 7'b1000000) begin
                n_fail++;
                $display("FAIL post_reset_seg k=%0d: got %b expected 1000000", k, seg);
            end
        end
    endtask

    task automatic test_hex_scan();
        logic [6:0] glyph [4];
        logic [3:0] e_an;
        int idx;
        int ticks;
        glyph = '{7'b0001110, 7'b0001000, 7'b0100100, 7'b1111001};
        restart_and_load(16'h12AF, 8'h00, 1'b0);
        ticks = 0;
        for (int c = 1; c <= 32; c++) begin
            step();
            idx  = (c / 4) % 4;
            e_an = 4'b1111;
            if ((c % 4) != 0) e_an[idx] = 1'b0;
            n_checks++;
            if (an !== e_an) begin
                n_fail++;
                $display("FAIL hex_an c=%0d: got %b expected %b", c, an, e_an);
            end
            n_checks++;
            if (seg !== glyph[idx]) begin
                n_fail++;
                $display("FAIL hex_seg c=%0d: got %b expected %b", c, seg, glyph[idx]);
            end
            n_checks++;
            if (frame_tick !== ((c % 16) == 15)) begin
                n_fail++;
                $display("FAIL hex_tick c=%0d: got %b", c, frame_tick);
            end
            if (frame_tick === 1'b1) ticks++;
        end
        n_checks++;
        if (ticks != 2) begin
            n_fail++;
            $display("FAIL hex_tick_count: got %0d expected 2", ticks);
        end
    endtask

    task automatic test_lz_blank();
        logic [6:0] g_a [4];
        logic [6:0] g_b [4];
        int idx;
        g_a = '{7'b1000000, 7'b0110000, 7'b1111111, 7'b1111111};
        g_b = '{7'b1000000, 7'b1111111, 7'b1111111, 7'b1111111};
        restart_and_load(16'h0030, 8'h00, 1'b1);
        for (int c = 1; c < 16; c++) begin
            step();
            idx = (c / 4) % 4;
            n_checks++;
            if (seg !== g_a[idx]) begin
                n_fail++;
                $display("FAIL lz_0030_seg c=%0d: got %b expected %b", c, seg, g_a[idx]);
            end
        end
        restart_and_load(16'h0000, 8'h00, 1'b1);
        for (int c = 1; c < 16; c++) begin
            step();
            idx = (c / 4) % 4;
            n_checks++;
            if (seg !== g_b[idx]) begin
                n_fail++;
                $display("FAIL lz_0000_seg c=%0d: got %b expected %b", c, seg, g_b[idx]);
            end
        end
    endtask

    task automatic test_modes();
        logic [6:0] glyph [4];
        logic [6:0] e_seg;
        int idx;
        glyph = '{7'b0010010, 7'b1111111, 7'b0111111, 7'b0010010};
        restart_and_load(16'h5555, 8'b11_10_01_00, 1'b0);
        for (int c = 1; c <= 80; c++) begin
            step();
            idx   = (c / 4) % 4;
            e_seg = glyph[idx];
            // digit 3 blinks: visible for two frames, blank for the next two
            if (idx == 3 && ((c / 16) % 4) >= 2) e_seg = 7'b1111111;
            n_checks++;
            if (seg !== e_seg) begin
                n_fail++;
                $display("FAIL modes_seg c=%0d: got %b expected %b", c, seg, e_seg);
            end
        end
    endtask

    task automatic test_load_boundary();
        logic [3:0] e_an;
        int idx;
        restart_and_load(16'h1234, 8'h00, 1'b0);
        step();
        step();
        // scan state now pcnt=3, idx=0
        value = 16'h9999;
        load  = 1'b1;
        step();
        load  = 1'b0;
        n_checks++;
        if (seg !== 7'b0011001 || an !== 4'b1110) begin
            n_fail++;
            $display("FAIL boundary_old seg/an: got %b/%b expected 0011001/1110", seg, an);
        end
        for (int c = 4; c < 16; c++) begin
            step();
            idx  = (c / 4) % 4;
            e_an = 4'b1111;
            if ((c % 4) != 0) e_an[idx] = 1'b0;
            n_checks++;
            if (seg !== 7'b0011000) begin
                n_fail++;
                $display("FAIL boundary_seg c=%0d: got %b expected 0011000", c, seg);
            end
            n_checks++;
            if (an !== e_an) begin
                n_fail++;
                $display("FAIL boundary_an c=%0d: got %b expected %b", c, an, e_an);
            end
            n_checks++;
            if ($countones(~an) > 1) begin
                n_fail++;
                $display("FAIL boundary_onehot c=%0d: got %b expected at most one zero", c, an);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] e_an;
        int idx;
        restart_and_load(16'h12AF, 8'h00, 1'b0);
        repeat (9) step();
        // scan state now pcnt=2, idx=2
        reset = 1'b1;
        step();
        n_checks++;
        if (an !== 4'b1111 || seg !== 7'b1111111 || frame_tick !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: got an=%b seg=%b tick=%b expected 1111/1111111/0",
                     an, seg, frame_tick);
        end
        reset = 1'b0;
        for (int c = 0; c < 8; c++) begin
            step();
            idx  = (c / 4) % 4;
            e_an = 4'b1111;
            if ((c % 4) != 0) e_an[idx] = 1'b0;
            n_checks++;
            if (an !== e_an) begin
                n_fail++;
                $display("FAIL mid_restart_an c=%0d: got %b expected %b", c, an, e_an);
            end
            n_checks++;
            if (seg !== 7'b1000000) begin
                n_fail++;
                $display("FAIL mid_restart_seg c=%0d: got %b expected 1000000", c, seg);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        value = 16'h0000;
        mode  = 8'h00;
        lz_en = 1'b0;
        load  = 1'b0;
        test_reset();
        test_hex_scan();
        test_lz_blank();
        test_modes();
        test_load_boundary();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
